// File: rtl/vector_writeback_sequencer.sv
// Write-back sequencer: in-order queue of vector results, one masked VRF write pulse each, retire on RF_FINISHED.
// Latency: push->write strobe 2 cycles, push->commit_valid 4 cycles; 3 cycles/entry steady state.
// Backpressure: in_ready low when queue full or rdy_in=0; optional WB_TIMEOUT_EN bounds WAIT and sets sticky wb_error.
`ifndef ONE_BYTE
`define ONE_BYTE 3'd0
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'd1
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'd2
`endif
`ifndef EIGHT_BYTE
`define EIGHT_BYTE 3'd3
`endif
`ifndef VECTOR_RF_WRITE
`define VECTOR_RF_WRITE 2'd1
`endif
`ifndef RF_NOP
`define RF_NOP 2'd0
`endif
`ifndef RF_FINISHED
`define RF_FINISHED 2'd1
`endif

module vector_writeback_sequencer #(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int QUEUE_DEPTH      = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rdy_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [4:0]                        in_rd,
    input  logic                              in_vm,
    input  logic [VECTOR_SIZE*LEN-1:0]        in_mask,
    input  logic [VECTOR_SIZE*LEN-1:0]        in_data,
    input  logic [ENTRY_INDEX_SIZE:0]         in_length,
    input  logic [2:0]                        in_data_type,
    output logic [1:0]                        rf_signal,
    output logic [4:0]                        rd,
    output logic                              vm,
    output logic [VECTOR_SIZE*LEN-1:0]        mask,
    output logic [VECTOR_SIZE*LEN-1:0]        data,
    output logic [ENTRY_INDEX_SIZE:0]         length,
    output logic [2:0]                        data_type,
    output logic                              write_back_enabled,
    input  logic [1:0]                        rf_status,
    output logic                              commit_valid,
    output logic [4:0]                        commit_rd,
    output logic                              busy,
    output logic                              wb_error
);
    localparam int VLEN = VECTOR_SIZE * LEN;
    localparam int LW   = ENTRY_INDEX_SIZE + 1;
    localparam int PW   = $clog2(QUEUE_DEPTH);
    localparam int CW   = PW + 1;

    // Element count never exceeds the slot count nor what fits in one register.
    function automatic int cap_for(input int bits);
        int c;
        c = VLEN / bits;
        return (c < VECTOR_SIZE) ? c : VECTOR_SIZE;
    endfunction

    localparam int CAP_1B = cap_for(8);
    localparam int CAP_2B = cap_for(16);
    localparam int CAP_4B = cap_for(32);
    localparam int CAP_8B = cap_for(64);

    typedef struct packed {
        logic [4:0]      rd;
        logic            vm;
        logic [VLEN-1:0] mask;
        logic [VLEN-1:0] data;
        logic [LW-1:0]   length;
        logic [2:0]      dtype;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETIRE} state_t;

    entry_t          q [QUEUE_DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr, nxt_ptr;
    logic [CW-1:0]   count;
    state_t          state, state_n;
    entry_t          push_entry, head, nxt, load_entry;
    logic [LW-1:0]   cap_len;
    logic            len_ok;
    logic            push, pop, load;
    logic            wbe_n, commit_n, commit_q;
    logic [1:0]      rfs_n;

`ifdef WB_TIMEOUT_EN
    logic [3:0] tcnt, tcnt_n;
    logic       drop, drop_n, err_q, err_n;
    assign wb_error = err_q;
`else
    assign wb_error = 1'b0;
`endif

    assign in_ready     = rdy_in && !rst && (count < CW'(QUEUE_DEPTH));
    assign push         = in_valid && in_ready;
    assign nxt_ptr      = rd_ptr + PW'(1);
    assign head         = q[rd_ptr];
    assign nxt          = q[nxt_ptr];
    assign busy         = (count != '0) || (state != IDLE);
    assign commit_valid = commit_q && rdy_in;

    always_comb begin
        cap_len = '0;
        len_ok  = 1'b1;
        case (in_data_type)
            `ONE_BYTE:   cap_len = LW'(CAP_1B);
            `TWO_BYTE:   cap_len = LW'(CAP_2B);
            `FOUR_BYTE:  cap_len = LW'(CAP_4B);
            `EIGHT_BYTE: cap_len = LW'(CAP_8B);
            default:     len_ok  = 1'b0;
        endcase
        push_entry.rd     = in_rd;
        push_entry.vm     = in_vm;
        push_entry.mask   = in_mask;
        push_entry.data   = in_data;
        push_entry.dtype  = in_data_type;
        push_entry.length = !len_ok ? '0 : ((in_length > cap_len) ? cap_len : in_length);
    end

    always_comb begin
        state_n    = state;
        load       = 1'b0;
        load_entry = head;
        pop        = 1'b0;
        wbe_n      = 1'b0;
        rfs_n      = 2'b00;
        commit_n   = 1'b0;
`ifdef WB_TIMEOUT_EN
        tcnt_n     = tcnt;
        drop_n     = drop;
        err_n      = err_q;
`endif
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load    = 1'b1;
                    state_n = (head.length == '0) ? RETIRE : ISSUE;
                end
            end
            ISSUE: begin
                wbe_n   = 1'b1;
                rfs_n   = `VECTOR_RF_WRITE;
                state_n = WAIT;
`ifdef WB_TIMEOUT_EN
                tcnt_n  = '0;
`endif
            end
            WAIT: begin
                if (rf_status == `RF_FINISHED) begin
                    state_n = RETIRE;
                end
`ifdef WB_TIMEOUT_EN
                else if (tcnt == 4'd14) begin
                    // 15th unanswered WAIT cycle: give up on this entry.
                    err_n   = 1'b1;
                    drop_n  = 1'b1;
                    state_n = RETIRE;
                end else begin
                    tcnt_n = tcnt + 4'd1;
                end
`endif
            end
            RETIRE: begin
                pop = 1'b1;
`ifdef WB_TIMEOUT_EN
                commit_n = !drop;
                drop_n   = 1'b0;
`else
                commit_n = 1'b1;
`endif
                if (count > CW'(1)) begin
                    load       = 1'b1;
                    load_entry = nxt;
                    state_n    = (nxt.length == '0) ? RETIRE : ISSUE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy_in && push) begin
            q[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            rd_ptr             <= '0;
            wr_ptr             <= '0;
            count              <= '0;
            rd                 <= '0;
            vm                 <= 1'b0;
            mask               <= '0;
            data               <= '0;
            length             <= '0;
            data_type          <= '0;
            write_back_enabled <= 1'b0;
            rf_signal          <= 2'b00;
            commit_q           <= 1'b0;
            commit_rd          <= '0;
`ifdef WB_TIMEOUT_EN
            tcnt               <= '0;
            drop               <= 1'b0;
            err_q              <= 1'b0;
`endif
        end else if (rdy_in) begin
            state <= state_n;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr    <= nxt_ptr;
                commit_rd <= rd;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (load) begin
                rd        <= load_entry.rd;
                vm        <= load_entry.vm;
                mask      <= load_entry.mask;
                data      <= load_entry.data;
                length    <= load_entry.length;
                data_type <= load_entry.dtype;
            end
            write_back_enabled <= wbe_n;
            rf_signal          <= rfs_n;
            commit_q           <= commit_n;
`ifdef WB_TIMEOUT_EN
            tcnt               <= tcnt_n;
            drop               <= drop_n;
            err_q              <= err_n;
`endif
        end
    end

endmodule

// File: tb/tb_vector_writeback_sequencer.sv
// Bench for vector_writeback_sequencer: scoreboard of expected writes/commits plus a VRF memory model.
// Latency: checks strobe at +2 and commit at +4 cycles; backpressure: full queue, rdy_in stall, mid-flight reset.
`timescale 1ns/1ps
`ifndef ONE_BYTE
`define ONE_BYTE 3'd0
`endif
`ifndef TWO_BYTE
`define TWO_BYTE 3'd1
`endif
`ifndef FOUR_BYTE
`define FOUR_BYTE 3'd2
`endif
`ifndef EIGHT_BYTE
`define EIGHT_BYTE 3'd3
`endif
`ifndef VECTOR_RF_WRITE
`define VECTOR_RF_WRITE 2'd1
`endif
`ifndef RF_NOP
`define RF_NOP 2'd0
`endif
`ifndef RF_FINISHED
`define RF_FINISHED 2'd1
`endif

module tb_vector_writeback_sequencer;
    localparam int LEN  = 32;
    localparam int VS   = 8;
    localparam int EIS  = 3;
    localparam int QD   = 2;
    localparam int VLEN = VS * LEN;
    localparam int LW   = EIS + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic            vm;
        logic [VLEN-1:0] mask;
        logic [VLEN-1:0] data;
        logic [LW-1:0]   length;
        logic [2:0]      dt;
    } wr_t;

    logic            clk, rst, rdy_in, in_valid, in_ready, in_vm, vm;
    logic [4:0]      in_rd, rd, commit_rd;
    logic [VLEN-1:0] in_mask, in_data, mask, data;
    logic [LW-1:0]   in_length, length;
    logic [2:0]      in_data_type, data_type;
    logic [1:0]      rf_signal, rf_status;
    logic            write_back_enabled, commit_valid, busy, wb_error;
    logic            rf_auto, rf_force;

    wr_t             exp_wr[$];
    logic [4:0]      exp_commit[$];
    logic [VLEN-1:0] vrf [32];
    int              checks, passes;

    vector_writeback_sequencer #(.LEN(LEN), .VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EIS), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_vm(in_vm),
        .in_mask(in_mask), .in_data(in_data), .in_length(in_length), .in_data_type(in_data_type),
        .rf_signal(rf_signal), .rd(rd), .vm(vm), .mask(mask), .data(data), .length(length),
        .data_type(data_type), .write_back_enabled(write_back_enabled), .rf_status(rf_status),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .busy(busy), .wb_error(wb_error)
    );

    // VRF answers in the same cycle as the strobe unless the bench withholds it.
    assign rf_status = ((rf_auto && write_back_enabled) || rf_force) ? `RF_FINISHED : `RF_NOP;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic wr_t mk(input logic [4:0] r, input logic v, input logic [VLEN-1:0] m,
                               input logic [VLEN-1:0] d, input logic [LW-1:0] l, input logic [2:0] t);
        wr_t e;
        e.rd = r; e.vm = v; e.mask = m; e.data = d; e.length = l; e.dt = t;
        return e;
    endfunction

    task automatic monitor();
        logic prev_wbe;
        wr_t  e;
        logic [4:0] ec;
        int   bits, idx;
        prev_wbe = 1'b0;
        forever begin
            @(negedge clk);
            if (write_back_enabled) begin
                checks++;
                if (prev_wbe) begin
                    $display("FAIL strobe_width: write_back_enabled=1 on consecutive cycles, want single pulse");
                end else if (exp_wr.size() == 0) begin
                    $display("FAIL unexpected_write: rd=%0d len=%0d, want no write", rd, length);
                end else begin
                    e = exp_wr.pop_front();
                    if (rd !== e.rd || vm !== e.vm || length !== e.length || data_type !== e.dt ||
                        rf_signal !== `VECTOR_RF_WRITE || data !== e.data || (!e.vm && mask !== e.mask))
                        $display("FAIL write_fields: got rd=%0d vm=%0d len=%0d dt=%0d sig=%0d, want rd=%0d vm=%0d len=%0d dt=%0d sig=%0d",
                                 rd, vm, length, data_type, rf_signal, e.rd, e.vm, e.length, e.dt, `VECTOR_RF_WRITE);
                    else
                        passes++;
                    bits = 8 << data_type;
                    for (int el = 0; el < int'(length); el++) begin
                        for (int b = 0; b < bits; b++) begin
                            idx = el * bits + b;
                            if (idx < VLEN && (vm || mask[el])) vrf[rd][idx] = data[idx];
                        end
                    end
                end
            end
            if (commit_valid) begin
                checks++;
                if (exp_commit.size() == 0) begin
                    $display("FAIL unexpected_commit: commit_rd=%0d, want none", commit_rd);
                end else begin
                    ec = exp_commit.pop_front();
                    if (commit_rd !== ec) $display("FAIL commit_order: commit_rd=%0d, want %0d", commit_rd, ec);
                    else passes++;
                end
            end
            prev_wbe = write_back_enabled;
        end
    endtask

    task automatic push(input logic [4:0] r, input logic v, input logic [VLEN-1:0] m,
                        input logic [VLEN-1:0] d, input logic [LW-1:0] l, input logic [2:0] t);
        int n = 0;
        in_rd = r; in_vm = v; in_mask = m; in_data = d; in_length = l; in_data_type = t;
        in_valid = 1'b1;
        while (!in_ready && n < 60) begin @(negedge clk); n++; end
        checks++;
        if (!in_ready) $display("FAIL push_accept: in_ready=%0d after %0d cycles, want 1", in_ready, n);
        else passes++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_commit.size() != 0 || busy) && n < budget) begin
            @(negedge clk); n++;
        end
        checks++;
        if (exp_wr.size() != 0 || exp_commit.size() != 0 || busy)
            $display("FAIL drain: pending writes=%0d commits=%0d busy=%0d, want 0/0/0",
                     exp_wr.size(), exp_commit.size(), busy);
        else passes++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: in_ready=%0d during rst, want 0", in_ready);
        else passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({write_back_enabled, rf_signal, commit_valid, busy, wb_error} !== 6'b0)
            $display("FAIL reset_ctrl: wbe=%0d sig=%0d cv=%0d busy=%0d err=%0d, want all 0",
                     write_back_enabled, rf_signal, commit_valid, busy, wb_error);
        else passes++;
        checks++;
        if ({rd, vm, length, data_type} !== '0 || data !== '0 || mask !== '0)
            $display("FAIL reset_fields: rd=%0d vm=%0d len=%0d dt=%0d data=%h, want 0", rd, vm, length, data_type, data);
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready_after: in_ready=%0d, want 1", in_ready);
        else passes++;
    endtask

    task automatic test_single_write();
        logic [VLEN-1:0] d;
        int n = 0;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(i);
        exp_wr.push_back(mk(5'd3, 1'b1, '0, d, 4'd8, `FOUR_BYTE));
        exp_commit.push_back(5'd3);
        push(5'd3, 1'b1, '0, d, 4'd8, `FOUR_BYTE);
        while (!write_back_enabled && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n != 2) $display("FAIL strobe_latency: strobe after %0d cycles, want 2", n);
        else passes++;
        while (!commit_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n != 4 || commit_rd !== 5'd3) $display("FAIL commit_latency: commit after %0d cycles rd=%0d, want 4 rd=3", n, commit_rd);
        else passes++;
        wait_drain(30);
        checks++;
        if (vrf[3] !== d) $display("FAIL single_vrf: v3=%h, want %h", vrf[3], d);
        else passes++;
    endtask

    task automatic test_masked_clamp();
        logic [VLEN-1:0] d, m, expv;
        m = '0;
        m[3:0] = 4'b0101;
        d = '0;
        for (int k = 0; k < 4; k++) d[k*64 +: 64] = {32'hD000_0000 + 32'(k), 32'hC000_0000 + 32'(k)};
        vrf[6] = {8{32'hAAAA_5555}};
        expv = {8{32'hAAAA_5555}};
        expv[63:0]    = d[63:0];
        expv[191:128] = d[191:128];
        exp_wr.push_back(mk(5'd6, 1'b0, m, d, 4'd4, `EIGHT_BYTE));
        exp_commit.push_back(5'd6);
        push(5'd6, 1'b0, m, d, 4'd7, `EIGHT_BYTE);
        wait_drain(30);
        checks++;
        if (length !== 4'd4) $display("FAIL clamp_len: length=%0d, want 4", length);
        else passes++;
        checks++;
        if (vrf[6] !== expv) $display("FAIL masked_vrf: v6=%h, want %h", vrf[6], expv);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [VLEN-1:0] d [4];
        logic [VLEN-1:0] expv;
        int n = 0;
        for (int i = 0; i < 4; i++)
            for (int w = 0; w < 8; w++) d[i][w*32 +: 32] = $urandom;
        for (int i = 0; i < 3; i++) begin
            exp_wr.push_back(mk(5'(i + 1), 1'b1, '0, d[i], 4'd8, `FOUR_BYTE));
            exp_commit.push_back(5'(i + 1));
        end
        push(5'd1, 1'b1, '0, d[0], 4'd8, `FOUR_BYTE);
        push(5'd2, 1'b1, '0, d[1], 4'd8, `FOUR_BYTE);
        checks++;
        if (in_ready !== 1'b0) $display("FAIL full_in_ready: in_ready=%0d with 2 queued, want 0", in_ready);
        else passes++;
        in_rd = 5'd3; in_vm = 1'b1; in_mask = '0; in_data = d[2]; in_length = 4'd8; in_data_type = `FOUR_BYTE;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n != 3 || !commit_valid || commit_rd !== 5'd1)
            $display("FAIL release_on_retire: ready after %0d cycles cv=%0d rd=%0d, want 3 cv=1 rd=1", n, commit_valid, commit_rd);
        else passes++;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        wait_drain(60);
        checks++;
        if (vrf[1] !== d[0] || vrf[2] !== d[1] || vrf[3] !== d[2])
            $display("FAIL b2b_vrf: v1=%h v2=%h v3=%h, want %h %h %h", vrf[1], vrf[2], vrf[3], d[0], d[1], d[2]);
        else passes++;
        // Same destination twice: second (1-byte, clamped to 8 elements) lands on top of the first.
        exp_wr.push_back(mk(5'd20, 1'b1, '0, d[3], 4'd8, `FOUR_BYTE));
        exp_wr.push_back(mk(5'd20, 1'b1, '0, ~d[3], 4'd8, `ONE_BYTE));
        exp_commit.push_back(5'd20);
        exp_commit.push_back(5'd20);
        push(5'd20, 1'b1, '0, d[3], 4'd8, `FOUR_BYTE);
        push(5'd20, 1'b1, '0, ~d[3], 4'd15, `ONE_BYTE);
        wait_drain(60);
        expv = d[3];
        expv[63:0] = ~d[3][63:0];
        checks++;
        if (vrf[20] !== expv) $display("FAIL same_rd_order: v20=%h, want %h", vrf[20], expv);
        else passes++;
    endtask

    task automatic test_zero_length();
        int n = 0;
        exp_commit.push_back(5'd5);
        push(5'd5, 1'b1, '0, {8{32'h1234_5678}}, 4'd0, `FOUR_BYTE);
        while (!commit_valid && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (n > 2 || !commit_valid || commit_rd !== 5'd5)
            $display("FAIL zero_len_commit: after %0d cycles cv=%0d rd=%0d, want <=2 cv=1 rd=5", n, commit_valid, commit_rd);
        else passes++;
        wait_drain(20);
        exp_commit.push_back(5'd7);
        push(5'd7, 1'b1, '0, {8{32'hFFFF_FFFF}}, 4'd5, 3'd6);
        wait_drain(20);
        checks++;
        if (vrf[5] !== '0 || vrf[7] !== '0) $display("FAIL zero_len_vrf: v5=%h v7=%h, want 0", vrf[5], vrf[7]);
        else passes++;
    endtask

    task automatic test_stall_reset();
        logic [VLEN-1:0] d;
        int n = 0;
        logic quiet;
        d = {8{32'hCAFE_0009}};
        rf_auto = 1'b0;
        exp_wr.push_back(mk(5'd9, 1'b1, '0, d, 4'd2, `FOUR_BYTE));
        push(5'd9, 1'b1, '0, d, 4'd2, `FOUR_BYTE);
        while (!write_back_enabled && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        rdy_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (commit_valid !== 1'b0 || write_back_enabled !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1 ||
                rd !== 5'd9 || length !== 4'd2 || data !== d)
                $display("FAIL stall_frozen: cyc=%0d cv=%0d wbe=%0d rdy=%0d busy=%0d rd=%0d len=%0d, want 0 0 0 1 9 2",
                         c, commit_valid, write_back_enabled, in_ready, busy, rd, length);
            else passes++;
        end
        rdy_in = 1'b1;
        exp_commit.push_back(5'd9);
        rf_force = 1'b1;
        @(posedge clk); @(negedge clk);
        rf_force = 1'b0;
        wait_drain(20);
        exp_wr.push_back(mk(5'd10, 1'b1, '0, d, 4'd8, `FOUR_BYTE));
        push(5'd10, 1'b1, '0, d, 4'd8, `FOUR_BYTE);
        push(5'd11, 1'b1, '0, ~d, 4'd8, `FOUR_BYTE);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++;
        if (busy !== 1'b0 || write_back_enabled !== 1'b0 || commit_valid !== 1'b0 || rd !== 5'd0)
            $display("FAIL mid_reset: busy=%0d wbe=%0d cv=%0d rd=%0d, want 0 0 0 0", busy, write_back_enabled, commit_valid, rd);
        else passes++;
        rst = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (commit_valid || write_back_enabled || busy) quiet = 1'b0;
        end
        checks++;
        if (!quiet || exp_wr.size() != 0) $display("FAIL post_reset_quiet: activity=%0d pending=%0d, want 0 0", !quiet, exp_wr.size());
        else passes++;
        rf_auto = 1'b1;
    endtask

`ifdef WB_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        rf_auto = 1'b0;
        exp_wr.push_back(mk(5'd12, 1'b1, '0, {8{32'h0000_000C}}, 4'd8, `FOUR_BYTE));
        exp_wr.push_back(mk(5'd13, 1'b1, '0, {8{32'h0000_000D}}, 4'd8, `FOUR_BYTE));
        exp_commit.push_back(5'd13);
        push(5'd12, 1'b1, '0, {8{32'h0000_000C}}, 4'd8, `FOUR_BYTE);
        push(5'd13, 1'b1, '0, {8{32'h0000_000D}}, 4'd8, `FOUR_BYTE);
        while (!write_back_enabled && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (!wb_error && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (n != 15 || !wb_error) $display("FAIL timeout_cycles: wb_error=%0d after %0d WAIT cycles, want 1 after 15", wb_error, n);
        else passes++;
        rf_auto = 1'b1;
        wait_drain(40);
        checks++;
        if (wb_error !== 1'b1 || vrf[13] !== {8{32'h0000_000D}})
            $display("FAIL timeout_recover: wb_error=%0d v13=%h, want 1 and next entry written", wb_error, vrf[13]);
        else passes++;
    endtask
`endif

    initial begin
        checks = 0; passes = 0;
        rst = 1'b1; rdy_in = 1'b1; in_valid = 1'b0;
        in_rd = '0; in_vm = 1'b0; in_mask = '0; in_data = '0; in_length = '0; in_data_type = '0;
        rf_auto = 1'b1; rf_force = 1'b0;
        for (int i = 0; i < 32; i++) vrf[i] = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_single_write();
        test_masked_clamp();
        test_back_to_back();
        test_zero_length();
        test_stall_reset();
`ifdef WB_TIMEOUT_EN
        test_timeout();
`else
        checks++;
        if (wb_error !== 1'b0) $display("FAIL wb_error_tied: wb_error=%0d, want 0", wb_error);
        else passes++;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
